// File: rtl/eq_pkg.sv
// Shared equalizer definitions: pot scan FSM states and the slot-to-ADC-channel map.
package eq_pkg;

    typedef enum logic [1:0] {
        GAP   = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } scan_state_t;

    localparam int NUM_POTS = 6;
    localparam logic [2:0] LAST_SLOT = 3'(NUM_POTS - 1);

    // Slots 0..5 are LP, B1, B2, B3, HP, VOLUME.
    localparam logic [2:0] POT_CHNL [NUM_POTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

    // Range-guarded lookup so a 3-bit slot index never reads past the table.
    function automatic logic [2:0] pot_chnl(input logic [2:0] slot);
        pot_chnl = POT_CHNL[0];
        for (int i = 0; i < NUM_POTS; i++) begin
            if (slot == 3'(i)) begin
                pot_chnl = POT_CHNL[i];
            end
        end
    endfunction

endpackage

// File: rtl/pot_scan_sequencer.sv
// Round-robin scheduler sharing the A2D interface among the six equalizer pots;
// issues one conversion at a time and keeps the latest result of each pot.
module pot_scan_sequencer
    import eq_pkg::*;
#(
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic [11:0] LP_pot,
    output logic [11:0] B1_pot,
    output logic [11:0] B2_pot,
    output logic [11:0] B3_pot,
    output logic [11:0] HP_pot,
    output logic [11:0] VOLUME,
    output logic        pots_vld,
    output logic        sweep_done,
    output logic        a2d_err
);

    localparam int CNT_W = $clog2((GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    scan_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       slot_reg, slot_next;
    logic             strt_cnv_reg, strt_cnv_next;
    logic [2:0]       chnnl_reg, chnnl_next;
    logic             pots_vld_reg, pots_vld_next;
    logic             sweep_done_reg, sweep_done_next;
    logic             a2d_err_reg, a2d_err_next;
    logic             capture, expire, retire;
    logic [11:0]      pot_reg [NUM_POTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= GAP;
        end else begin
            state_reg <= state_next;
        end
    end

    // The GAP phase runs GAP_CYC+1 cycles so the strt_cnv register, which
    // follows the START transition, fires on edge GAP_CYC+1 after reset.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            GAP:     if (cnt_reg == GAP_LAST) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (cnv_cmplt || (cnt_reg == '0)) state_next = GAP;
            default: state_next = GAP;
        endcase
    end

    // One counter serves both phases: counts up through GAP from zero and
    // down through WAIT from the timeout load; completion beats expiry.
    always_comb begin
        capture = (state_reg == WAIT) && cnv_cmplt;
        expire  = (state_reg == WAIT) && !cnv_cmplt && (cnt_reg == '0);
        retire  = capture || expire;

        cnt_next = cnt_reg;
        case (state_reg)
            GAP:     cnt_next = (cnt_reg == GAP_LAST) ? '0 : cnt_reg + CNT_ONE;
            START:   cnt_next = TO_LOAD;
            WAIT:    cnt_next = retire ? '0 : cnt_reg - CNT_ONE;
            default: cnt_next = '0;
        endcase

        slot_next = slot_reg;
        if (retire) begin
            slot_next = (slot_reg == LAST_SLOT) ? 3'd0 : slot_reg + 3'd1;
        end

        strt_cnv_next   = (state_next == START);
        chnnl_next      = pot_chnl(slot_next);
        sweep_done_next = retire && (slot_reg == LAST_SLOT);
        pots_vld_next   = pots_vld_reg || sweep_done_next;
        a2d_err_next    = a2d_err_reg || expire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            slot_reg       <= 3'd0;
            strt_cnv_reg   <= 1'b0;
            chnnl_reg      <= 3'd1;
            pots_vld_reg   <= 1'b0;
            sweep_done_reg <= 1'b0;
            a2d_err_reg    <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            slot_reg       <= slot_next;
            strt_cnv_reg   <= strt_cnv_next;
            chnnl_reg      <= chnnl_next;
            pots_vld_reg   <= pots_vld_next;
            sweep_done_reg <= sweep_done_next;
            a2d_err_reg    <= a2d_err_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_POTS; gi++) begin : g_pot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pot_reg[gi] <= 12'h000;
                end else if (capture && (slot_reg == 3'(gi))) begin
                    pot_reg[gi] <= res;
                end
            end
        end
    endgenerate

    assign strt_cnv   = strt_cnv_reg;
    assign chnnl      = chnnl_reg;
    assign pots_vld   = pots_vld_reg;
    assign sweep_done = sweep_done_reg;
    assign a2d_err    = a2d_err_reg;
    assign LP_pot     = pot_reg[0];
    assign B1_pot     = pot_reg[1];
    assign B2_pot     = pot_reg[2];
    assign B3_pot     = pot_reg[3];
    assign HP_pot     = pot_reg[4];
    assign VOLUME     = pot_reg[5];

endmodule

// File: tb/tb_pot_scan_sequencer.sv
// Directed bench for pot_scan_sequencer: the bench plays the A2D interface and
// checks slot order, captured results, timeout, spurious/coincident completion and reset.
module tb_pot_scan_sequencer;

    localparam int GAP_CYC     = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int LAT         = 3;
    localparam int BOUND       = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnv_cmplt = 1'b0;
    logic [11:0] res = 12'h000;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [11:0] LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOLUME;
    logic        pots_vld, sweep_done, a2d_err;

    pot_scan_sequencer #(
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .strt_cnv   (strt_cnv),
        .chnnl      (chnnl),
        .cnv_cmplt  (cnv_cmplt),
        .res        (res),
        .LP_pot     (LP_pot),
        .B1_pot     (B1_pot),
        .B2_pot     (B2_pot),
        .B3_pot     (B3_pot),
        .HP_pot     (HP_pot),
        .VOLUME     (VOLUME),
        .pots_vld   (pots_vld),
        .sweep_done (sweep_done),
        .a2d_err    (a2d_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] chan;
        logic [11:0] val1;
        logic [11:0] val2;
    } slot_vec_t;

    slot_vec_t   tbl [6];
    logic [11:0] exp_pot [6];
    logic [2:0]  chlog [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [11:0] pot_out(input int i);
        case (i)
            0:       return LP_pot;
            1:       return B1_pot;
            2:       return B2_pot;
            3:       return B3_pot;
            4:       return HP_pot;
            default: return VOLUME;
        endcase
    endfunction

    task automatic check_all_pots(input string tag);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s.%s", tag, tbl[i].name), 32'(pot_out(i)), 32'(exp_pot[i]));
        end
    endtask

    // Returns at the falling edge inside the START cycle.
    task automatic wait_strt(input string tag, input int exp_cyc, input logic [2:0] exp_ch);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!strt_cnv && n < BOUND);
        check({tag, ".strt_delay"}, 32'(n), 32'(exp_cyc));
        check({tag, ".chnnl"}, 32'(chnnl), 32'(exp_ch));
        chlog.push_back(chnnl);
    endtask

    // Completion arrives in WAIT cycle 'lat'; returns in the cycle after retire.
    task automatic respond(input string tag, input int lat, input logic [11:0] v, input logic [2:0] ch);
        repeat (lat) @(negedge clk);
        check({tag, ".chnnl_stable"}, 32'(chnnl), 32'(ch));
        cnv_cmplt = 1'b1;
        res       = v;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        res       = 12'h000;
    endtask

    task automatic run_slot(input string tag, input int i, input int gap, input logic [11:0] v,
                            input logic exp_vld, input logic exp_err);
        wait_strt(tag, gap, tbl[i].chan);
        respond(tag, LAT, v, tbl[i].chan);
        exp_pot[i] = v;
        check({tag, ".pot"}, 32'(pot_out(i)), 32'(v));
        check({tag, ".sweep_done"}, 32'(sweep_done), 32'(i == 5));
        check({tag, ".pots_vld"}, 32'(pots_vld), 32'(exp_vld));
        check({tag, ".a2d_err"}, 32'(a2d_err), 32'(exp_err));
    endtask

    initial begin
        tbl[0] = '{"LP", 3'd1, 12'h111, 12'hA01};
        tbl[1] = '{"B1", 3'd0, 12'h222, 12'hB02};
        tbl[2] = '{"B2", 3'd4, 12'h333, 12'hC03};
        tbl[3] = '{"B3", 3'd2, 12'h444, 12'hD04};
        tbl[4] = '{"HP", 3'd3, 12'h555, 12'hE05};
        tbl[5] = '{"VOL", 3'd7, 12'h666, 12'hF06};
        for (int i = 0; i < 6; i++) exp_pot[i] = 12'h000;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst.strt_cnv", 32'(strt_cnv), 32'd0);
        check("rst.chnnl", 32'(chnnl), 32'd1);
        check("rst.pots_vld", 32'(pots_vld), 32'd0);
        check("rst.sweep_done", 32'(sweep_done), 32'd0);
        check("rst.a2d_err", 32'(a2d_err), 32'd0);
        check_all_pots("rst");
        rst_n = 1'b1;

        // Sweep 1: first strt_cnv GAP_CYC+1 clocks after release, then the same gap after each retire
        for (int i = 0; i < 6; i++)
            run_slot($sformatf("s1.%s", tbl[i].name), i, GAP_CYC + 1, tbl[i].val1, i == 5, 1'b0);

        // Spurious completion in GAP is ignored; it consumes one of the gap cycles
        cnv_cmplt = 1'b1;
        res       = 12'hFFF;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        res       = 12'h000;
        check_all_pots("spur");
        check("spur.a2d_err", 32'(a2d_err), 32'd0);

        // Sweep 2 overwrites every register
        for (int i = 0; i < 6; i++)
            run_slot($sformatf("s2.%s", tbl[i].name), i, (i == 0) ? GAP_CYC : GAP_CYC + 1,
                     tbl[i].val2, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++)
            check($sformatf("chlog[%0d]", i), 32'(chlog[i]), 32'(tbl[i % 6].chan));

        // Sweep 3: slot 2 never completes
        run_slot("s3.LP", 0, GAP_CYC + 1, tbl[0].val1, 1'b1, 1'b0);
        run_slot("s3.B1", 1, GAP_CYC + 1, tbl[1].val1, 1'b1, 1'b0);
        wait_strt("s3.B2", GAP_CYC + 1, tbl[2].chan);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!a2d_err && n < BOUND);
            check("to.err_delay", 32'(n), 32'(TIMEOUT_CYC + 1));
        end
        check("to.B2_kept", 32'(B2_pot), 32'(exp_pot[2]));
        check("to.sweep_done", 32'(sweep_done), 32'd0);
        for (int i = 3; i < 6; i++)
            run_slot($sformatf("s3.%s", tbl[i].name), i, GAP_CYC + 1, tbl[i].val1, 1'b1, 1'b1);

        // Sweep 4: reset in WAIT of slot 3
        for (int i = 0; i < 3; i++)
            run_slot($sformatf("s4.%s", tbl[i].name), i, GAP_CYC + 1, tbl[i].val2, 1'b1, 1'b1);
        wait_strt("s4.B3", GAP_CYC + 1, tbl[3].chan);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) exp_pot[i] = 12'h000;
        check_all_pots("mrst");
        check("mrst.pots_vld", 32'(pots_vld), 32'd0);
        check("mrst.a2d_err", 32'(a2d_err), 32'd0);
        check("mrst.chnnl", 32'(chnnl), 32'd1);
        check("mrst.strt_cnv", 32'(strt_cnv), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Restart at slot 0; completion lands on the expiry cycle and wins
        wait_strt("post.LP", GAP_CYC + 1, tbl[0].chan);
        respond("coinc.LP", TIMEOUT_CYC, 12'h5A5, tbl[0].chan);
        exp_pot[0] = 12'h5A5;
        check("coinc.a2d_err", 32'(a2d_err), 32'd0);
        check_all_pots("coinc");
        wait_strt("coinc.next", GAP_CYC + 1, tbl[1].chan);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
